// File: rtl/dr_pkg.sv
`default_nettype none
// ============================================================================
// dr_pkg : dual-rail codeword constants, FSM state types and word classifiers
// Revision: 1.0
// ============================================================================
package dr_pkg;

  localparam logic [1:0] DR_NULL = 2'b00;
  localparam logic [1:0] DR_F    = 2'b01;
  localparam logic [1:0] DR_T    = 2'b10;
  localparam logic [1:0] DR_ILL  = 2'b11;

  // Classifiers take a word zero-padded to this many bits plus its real width.
  localparam int DR_MAX_WIDTH = 64;

  typedef logic [2*DR_MAX_WIDTH-1:0] dr_word_t;

  typedef enum logic [0:0] {
    IN_DATA = 1'b0,
    IN_NULL = 1'b1
  } in_state_t;

  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_DATA = 1'b1
  } out_state_t;

  function automatic logic dr_is_valid(input dr_word_t word, input int width);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DR_MAX_WIDTH; i++) begin
      if (i < width && word[2*i +: 2] != DR_T && word[2*i +: 2] != DR_F) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic dr_is_null(input dr_word_t word, input int width);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DR_MAX_WIDTH; i++) begin
      if (i < width && word[2*i +: 2] != DR_NULL) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic dr_has_illegal(input dr_word_t word, input int width);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DR_MAX_WIDTH; i++) begin
      if (i < width && word[2*i +: 2] == DR_ILL) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dr_ack_join.sv
`default_nettype none
// ============================================================================
// dr_ack_join : NUM_ACK-input C-element join of consumer acknowledges
// Revision: 1.0
// ============================================================================
module dr_ack_join #(
  parameter int NUM_ACK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ACK-1:0] ack_in,
  output logic               all_high,
  output logic               all_low,
  output logic               join_state
);

  logic r_join;

  assign all_high   = &ack_in;
  assign all_low    = ~|ack_in;
  assign join_state = r_join;

  // Muller behaviour: switch only on unanimous inputs, hold on any mix.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_join <= 1'b0;
    end else if (all_high) begin
      r_join <= 1'b1;
    end else if (all_low) begin
      r_join <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dr_fifo_fanout.sv
`default_nettype none
// ============================================================================
// dr_fifo_fanout : buffered four-phase dual-rail stage with C-element fan-out
// Revision: 1.0
// ============================================================================
module dr_fifo_fanout
  import dr_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 4,
  parameter int NUM_ACK = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*WIDTH-1:0]         data_in,
  output logic                       ack,
  output logic [2*WIDTH-1:0]         data_out,
  input  logic [NUM_ACK-1:0]         ack_in,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH-1);

  in_state_t          r_in_state;
  out_state_t         r_out_state;
  logic               r_ack;
  logic               r_err;
  logic [2*WIDTH-1:0] r_data_out;
  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];

  dr_word_t           w_in_ext;
  logic [WIDTH-1:0]   w_true;
  logic [2*WIDTH-1:0] w_head_dr;
  logic               w_valid, w_null, w_illegal;
  logic               w_all_high, w_all_low, w_join;
  logic               w_push, w_pop;

  always_comb begin
    w_in_ext = '0;
    w_in_ext[2*WIDTH-1:0] = data_in;
  end

  assign w_valid   = dr_is_valid(w_in_ext, WIDTH);
  assign w_null    = dr_is_null(w_in_ext, WIDTH);
  assign w_illegal = dr_has_illegal(w_in_ext, WIDTH);

  always_comb begin
    w_true    = '0;
    w_head_dr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_true[i]          = data_in[2*i+1];
      w_head_dr[2*i+1]   = r_mem[r_rd_ptr][i];
      w_head_dr[2*i]     = ~r_mem[r_rd_ptr][i];
    end
  end

  dr_ack_join #(
    .NUM_ACK (NUM_ACK)
  ) u_ack_join (
    .clk        (clk),
    .rst        (rst),
    .ack_in     (ack_in),
    .all_high   (w_all_high),
    .all_low    (w_all_low),
    .join_state (w_join)
  );

  assign w_push = (r_in_state == IN_DATA) && w_valid && (r_count < c_full);
  // Join still low means this is the first unanimous-high edge since presentation.
  assign w_pop  = (r_out_state == OUT_DATA) && w_all_high && !w_join;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_state <= IN_DATA;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_wr_ptr   <= '0;
    end else begin
      case (r_in_state)
        IN_DATA: begin
          if (w_illegal) begin
            r_err <= 1'b1;
          end else if (w_push) begin
            r_ack      <= 1'b1;
            r_in_state <= IN_NULL;
            r_wr_ptr   <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
          end
        end
        IN_NULL: begin
          if (w_null) begin
            r_ack      <= 1'b0;
            r_in_state <= IN_DATA;
          end
        end
        default: r_in_state <= IN_DATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_true;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_state <= OUT_IDLE;
      r_data_out  <= '0;
      r_rd_ptr    <= '0;
    end else begin
      case (r_out_state)
        OUT_IDLE: begin
          if (r_count != '0 && w_all_low) begin
            r_data_out  <= w_head_dr;
            r_out_state <= OUT_DATA;
          end
        end
        OUT_DATA: begin
          if (w_pop) begin
            r_data_out  <= '0;
            r_rd_ptr    <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            r_out_state <= OUT_IDLE;
          end
        end
        default: r_out_state <= OUT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign data_out = r_data_out;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dr_fifo_fanout.sv
`default_nettype none
// ============================================================================
// tb_dr_fifo_fanout : scoreboard bench for the buffered dual-rail fan-out stage
// Revision: 1.0
// ============================================================================
module tb_dr_fifo_fanout;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic       ack;
  logic [3:0] data_out;
  logic [3:0] ack_in;
  logic [2:0] count;
  logic       err;

  logic [3:0] sb_q[$];
  int         n_vec;
  int         n_err;

  dr_fifo_fanout #(
    .WIDTH   (2),
    .DEPTH   (4),
    .NUM_ACK (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .ack      (ack),
    .data_out (data_out),
    .ack_in   (ack_in),
    .count    (count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] w);
    int n;
    data_in = w;
    n = 0;
    do begin step(); n++; end while (!ack && n < 10);
    check("send_ack_hi", {31'd0, ack}, 32'd1);
    sb_q.push_back(w);
    data_in = 4'b0000;
    n = 0;
    do begin step(); n++; end while (ack && n < 10);
    check("send_ack_lo", {31'd0, ack}, 32'd0);
  endtask

  task automatic recv();
    int n;
    n = 0;
    while (data_out == 4'b0000 && n < 10) begin step(); n++; end
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      check("recv_word", {28'd0, data_out}, {28'd0, sb_q[0]});
      void'(sb_q.pop_front());
    end
    ack_in = 4'b1111;
    step();
    check("recv_null", {28'd0, data_out}, 32'd0);
    ack_in = 4'b0000;
    step();
  endtask

  initial begin
    logic [3:0] words [4];
    words[0] = 4'b1010; words[1] = 4'b1001; words[2] = 4'b0110; words[3] = 4'b0101;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    data_in = 4'b0000;
    ack_in = 4'b0000;
    step(); step();
    rst = 1'b0;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dout", {28'd0, data_out}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    step();

    // Single word latency and partial-ack hold
    data_in = 4'b1001;
    step();
    check("sw_ack", {31'd0, ack}, 32'd1);
    check("sw_count", {29'd0, count}, 32'd1);
    step();
    check("sw_dout", {28'd0, data_out}, 32'h9);
    ack_in = 4'b0111;
    data_in = 4'b0000;
    step();
    check("mix_hold", {28'd0, data_out}, 32'h9);
    check("sw_ack_lo", {31'd0, ack}, 32'd0);
    check("mix_count", {29'd0, count}, 32'd1);
    ack_in = 4'b1111;
    step();
    check("pop_null", {28'd0, data_out}, 32'd0);
    check("pop_count", {29'd0, count}, 32'd0);

    // Mixed acks in idle delay the next presentation
    ack_in = 4'b0011;
    data_in = 4'b0110;
    step();
    check("mix_push", {29'd0, count}, 32'd1);
    data_in = 4'b0000;
    step();
    check("mix_nopres", {28'd0, data_out}, 32'd0);
    ack_in = 4'b0000;
    step();
    check("mix_pres", {28'd0, data_out}, 32'h6);
    ack_in = 4'b1111;
    step();
    check("mix_pop", {29'd0, count}, 32'd0);
    ack_in = 4'b0000;
    step();

    // Fill to DEPTH with consumers stalled, then a blocked fifth word
    for (int i = 0; i < 4; i++) send(words[i]);
    check("full_count", {29'd0, count}, 32'd4);
    data_in = 4'b0101;
    step();
    check("full_ack0", {31'd0, ack}, 32'd0);
    check("full_hold", {29'd0, count}, 32'd4);
    check("full_head", {28'd0, data_out}, {28'd0, sb_q[0]});
    void'(sb_q.pop_front());
    ack_in = 4'b1111;
    step();
    check("full_pop", {29'd0, count}, 32'd3);
    check("full_ack_wait", {31'd0, ack}, 32'd0);
    step();
    check("full_accept", {31'd0, ack}, 32'd1);
    check("full_recount", {29'd0, count}, 32'd4);
    sb_q.push_back(4'b0101);
    data_in = 4'b0000;
    ack_in = 4'b0000;
    step();
    for (int i = 0; i < 4; i++) recv();
    check("drain_count", {29'd0, count}, 32'd0);

    // Simultaneous push and pop at count=2 across pointer wrap
    send(4'b1010);
    send(4'b0110);
    check("pp_start", {29'd0, count}, 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("pp_head", {28'd0, data_out}, {28'd0, sb_q[0]});
      data_in = words[(i + 1) % 4];
      ack_in = 4'b1111;
      step();
      check("pp_count", {29'd0, count}, 32'd2);
      check("pp_ack", {31'd0, ack}, 32'd1);
      void'(sb_q.pop_front());
      sb_q.push_back(words[(i + 1) % 4]);
      data_in = 4'b0000;
      ack_in = 4'b0000;
      step();
    end
    recv();
    recv();
    check("pp_empty", {29'd0, count}, 32'd0);

    // Illegal codeword is flagged, never stored, and err is sticky
    data_in = 4'b1101;
    step();
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_count", {29'd0, count}, 32'd0);
    check("ill_ack", {31'd0, ack}, 32'd0);
    data_in = 4'b0000;
    step();
    send(4'b1010);
    check("ill_sticky", {31'd0, err}, 32'd1);
    check("ill_accept", {29'd0, count}, 32'd1);
    recv();

    // Reset with three words buffered
    for (int i = 0; i < 3; i++) send(words[i]);
    check("pre_rst_count", {29'd0, count}, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    check("mrst_count", {29'd0, count}, 32'd0);
    check("mrst_ack", {31'd0, ack}, 32'd0);
    check("mrst_dout", {28'd0, data_out}, 32'd0);
    check("mrst_err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
